// File: rtl/debounce_bank_if.sv
// rtl/debounce_bank_if.sv - debounced edge event stream between debounce_bank and its consumer
interface debounce_bank_if #(
    parameter int N_CH       = 25,
    parameter int FIFO_DEPTH = 8
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               o_ev_valid;
    logic [CH_W-1:0]    o_ev_ch;
    logic               o_ev_press;
    logic               i_ev_ready;
    logic [COUNT_W-1:0] o_ev_count;

    modport master (
        output o_ev_valid,
        output o_ev_ch,
        output o_ev_press,
        output o_ev_count,
        input  i_ev_ready
    );

    modport slave (
        input  o_ev_valid,
        input  o_ev_ch,
        input  o_ev_press,
        input  o_ev_count,
        output i_ev_ready
    );
endinterface

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel synchroniser/debouncer with press/release event FIFO
module debounce_bank #(
    parameter int N_CH          = 25,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_CH-1:0]   i_raw,
    output logic [N_CH-1:0]   o_state,
    output logic [N_CH-1:0]   o_press,
    output logic [N_CH-1:0]   o_release,
    output logic              o_overflow,
    input  logic              i_clr_ovf,
    debounce_bank_if.master   ev
);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = AW + 1;
    localparam logic [N_CH-1:0]    IDLE_LEVEL = ACTIVE_LOW ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] FIFO_FULL  = COUNT_W'(FIFO_DEPTH);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  s;
    logic [CNT_W-1:0] cnt [N_CH];

    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  dir;
    logic [N_CH-1:0]  strobe;
    logic [N_CH-1:0]  cancel;
    logic [N_CH-1:0]  push_sel;

    logic             sel_found;
    logic [CH_W-1:0]  sel_ch;
    logic             sel_dir;
    logic             push;
    logic             pop;
    logic             full;

    logic [CH_W-1:0]    mem_ch    [FIFO_DEPTH];
    logic               mem_press [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [COUNT_W-1:0] count;

    // two-flop synchroniser; idle level on reset so release creates no edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    // per-channel debounce counter; level accepted after STABLE_CYCLES disagreeing cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state   <= '0;
            o_press   <= '0;
            o_release <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                o_press[i]   <= 1'b0;
                o_release[i] <= 1'b0;
                if (s[i] == o_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    o_state[i]   <= s[i];
                    cnt[i]       <= '0;
                    o_press[i]   <= s[i];
                    o_release[i] <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // lowest pending channel wins the single push slot this cycle
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        sel_dir   = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(i);
                sel_dir   = dir[i];
            end
        end
    end

    assign full = (count == FIFO_FULL);
    assign push = sel_found & ~full;
    assign pop  = (count != '0) & ev.i_ev_ready;

    // a new edge on a channel whose previous edge is still waiting annihilates both
    always_comb begin
        strobe   = o_press | o_release;
        push_sel = '0;
        cancel   = '0;
        for (int i = 0; i < N_CH; i++) begin
            push_sel[i] = push && (sel_ch == CH_W'(i));
            cancel[i]   = strobe[i] & pend[i] & ~push_sel[i];
        end
    end

    // pending/direction bits and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend       <= '0;
            dir        <= '0;
            o_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (strobe[i]) begin
                    if (cancel[i]) begin
                        pend[i] <= 1'b0;
                    end else begin
                        pend[i] <= 1'b1;
                        dir[i]  <= o_press[i];
                    end
                end else if (push_sel[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (|cancel) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
        end
    end

    // show-ahead event FIFO; storage is reset so the head is never X
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ch[i]    <= '0;
                mem_press[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_ch[wr_ptr]    <= sel_ch;
                mem_press[wr_ptr] <= sel_dir;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign ev.o_ev_valid = (count != '0);
    assign ev.o_ev_ch    = mem_ch[rd_ptr];
    assign ev.o_ev_press = mem_press[rd_ptr];
    assign ev.o_ev_count = count;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank
module tb_debounce_bank;
    localparam int N_CH          = 25;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 4;
    localparam int FIFO_DEPTH    = 8;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] state;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic            overflow;
    logic            clr_ovf;

    int checks = 0;
    int errors = 0;
    int q[$];

    debounce_bank_if #(.N_CH(N_CH), .FIFO_DEPTH(FIFO_DEPTH)) ev ();

    debounce_bank #(
        .N_CH(N_CH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W(CNT_W),
        .ACTIVE_LOW(1'b1),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_raw(raw),
        .o_state(state),
        .o_press(press),
        .o_release(rel),
        .o_overflow(overflow),
        .i_clr_ovf(clr_ovf),
        .ev(ev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] head();
        return {26'd0, ev.o_ev_ch, ev.o_ev_press};
    endfunction

    // pop every expected event from the FIFO, comparing heads in order
    task automatic drain(input string tag, input int budget);
        int n = 0;
        ev.i_ev_ready = 1'b1;
        while (q.size() > 0 && n < budget) begin
            if (ev.o_ev_valid) begin
                check(tag, head(), 32'(q.pop_front()));
            end
            tick();
            n++;
        end
        if (q.size() > 0) begin
            check({tag, "_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
        ev.i_ev_ready = 1'b0;
        tick();
        check({tag, "_empty"}, 32'(ev.o_ev_valid), 32'd0);
    endtask

    function automatic int exp_ev(input int ch, input int pr);
        return ch * 2 + pr;
    endfunction

    initial begin
        logic seen;
        rst_n         = 1'b0;
        raw           = '1;
        clr_ovf       = 1'b0;
        ev.i_ev_ready = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(ev.o_ev_valid), 32'd0);
        check("rst_count", 32'(ev.o_ev_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_head_ch", 32'(ev.o_ev_ch), 32'd0);

        // single press latency: edge to o_state change is 2 + STABLE_CYCLES
        raw[3] = 1'b0;
        q.push_back(exp_ev(3, 1));
        wait_n(5);
        check("lat_before", 32'(state[3]), 32'd0);
        tick();
        check("lat_state", 32'(state[3]), 32'd1);
        check("lat_press", 32'(press[3]), 32'd1);
        tick();
        check("lat_press_gone", 32'(press[3]), 32'd0);
        tick();
        check("lat_count", 32'(ev.o_ev_count), 32'd1);
        drain("ev_single", 20);

        // a 3-cycle glitch is shorter than STABLE_CYCLES and must vanish
        raw[5] = 1'b0;
        seen = 1'b0;
        wait_n(3);
        raw[5] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            seen = seen | state[5] | press[5] | ev.o_ev_valid;
            tick();
        end
        check("glitch_no_effect", 32'(seen), 32'd0);
        check("glitch_count", 32'(ev.o_ev_count), 32'd0);

        // simultaneous presses enter in ascending channel order
        raw[7] = 1'b0;
        raw[2] = 1'b0;
        raw[20] = 1'b0;
        q.push_back(exp_ev(2, 1));
        q.push_back(exp_ev(7, 1));
        q.push_back(exp_ev(20, 1));
        wait_n(12);
        check("simul_count", 32'(ev.o_ev_count), 32'd3);
        drain("ev_simul", 20);

        // ten presses against an eight-deep FIFO: two wait as pending
        for (int c = 10; c < 20; c++) begin
            raw[c] = 1'b0;
            q.push_back(exp_ev(c, 1));
        end
        wait_n(20);
        check("full_count", 32'(ev.o_ev_count), 32'd8);
        ev.i_ev_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("full_pop", head(), 32'(q.pop_front()));
            tick();
        end
        ev.i_ev_ready = 1'b0;
        wait_n(4);
        check("refill_count", 32'(ev.o_ev_count), 32'd8);
        check("full_no_ovf", 32'(overflow), 32'd0);
        drain("ev_full", 40);

        // press+release of ch 9 while stuck behind a full FIFO cancels both
        for (int c = 10; c < 20; c++) begin
            raw[c] = 1'b1;
            q.push_back(exp_ev(c, 0));
        end
        wait_n(20);
        check("ovf_full", 32'(ev.o_ev_count), 32'd8);
        raw[9] = 1'b0;
        wait_n(10);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        raw[9] = 1'b1;
        wait_n(10);
        check("ovf_set", 32'(overflow), 32'd1);
        drain("ev_ovf", 40);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // async reset mid-count with a non-empty FIFO
        raw[7] = 1'b1;
        raw[20] = 1'b1;
        wait_n(12);
        check("pre_rst_count", 32'(ev.o_ev_count), 32'd2);
        raw[2] = 1'b1;
        wait_n(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_valid", 32'(ev.o_ev_valid), 32'd0);
        check("arst_count", 32'(ev.o_ev_count), 32'd0);
        check("arst_strobes", 32'(press | rel), 32'd0);
        raw = '1;
        q.delete();
        wait_n(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | ev.o_ev_valid | (|state) | (|press) | (|rel);
            tick();
        end
        check("post_rst_idle", 32'(seen), 32'd0);
        check("post_rst_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised N-channel replacement for the per-pin debouncer instances on the key/GPIO input path.
- Synchronises, polarity-normalises and debounces N raw inputs; outputs the stable level vector and one-cycle press/release strobes.
- Serialises every debounced edge into a show-ahead event FIFO with a valid/ready handshake, so the teaching and synth logic consume discrete note-on/note-off events instead of polling levels.

Parameters:
- N_CH, 25, number of input channels (1..64)
- STABLE_CYCLES, 500000, consecutive disagreeing cycles required before a level is accepted (10 ms at 50 MHz); must be >= 2
- CNT_W, 20, per-channel counter width; must satisfy 2^CNT_W > STABLE_CYCLES
- ACTIVE_LOW, 1, 1 = raw input low means pressed (input inverted before debounce)
- FIFO_DEPTH, 8, event FIFO entries, power of two >= 2

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_raw  in  N_CH  raw asynchronous pin levels
- o_state  out  N_CH  debounced level, 1 = pressed
- o_press  out  N_CH  one-cycle strobe on debounced 0->1
- o_release  out  N_CH  one-cycle strobe on debounced 1->0
- o_ev_valid  out  1  FIFO head valid
- o_ev_ch  out  $clog2(N_CH)  channel index of head event
- o_ev_press  out  1  1 = press, 0 = release
- i_ev_ready  in  1  consumer accepts head when high with o_ev_valid
- o_ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: at least one event lost
- i_clr_ovf  in  1  synchronous clear of o_overflow

Behaviour:
- Reset (async assert, sync release): sync flops load idle level (all 1 if ACTIVE_LOW else 0); counters, o_state, o_press, o_release, pending bits, FIFO pointers, o_ev_valid, o_ev_count, o_overflow = 0. No events are generated by reset release with idle inputs.
- Sync: 2-flop synchroniser per channel, then inversion if ACTIVE_LOW; result is s[i].
- Debounce per channel: if s[i] == o_state[i], counter <= 0. Otherwise counter increments; on the cycle the counter equals STABLE_CYCLES-1 (s still differing), o_state[i] toggles, counter <= 0, and o_press[i] or o_release[i] pulses in that same cycle. A glitch shorter than STABLE_CYCLES resets the count and produces no change. Latency from raw edge to o_state change = 2 + STABLE_CYCLES cycles.
- Pending: each strobe sets pend[i] and dir[i] (1 = press). If a strobe arrives while pend[i] is already set, the opposite edge cancels it: pend[i] <= 0 and o_overflow <= 1 (both edges lost).
- Scanner: each cycle, the lowest-index i with pend[i] set is pushed as {i, dir[i]} if FIFO not full at the start of the cycle; that pend[i] clears. One push per cycle maximum. Simultaneous edges on several channels therefore enter the FIFO in ascending index order, one per cycle.
- FIFO: show-ahead; head drives o_ev_ch/o_ev_press whenever o_ev_valid. Pop on o_ev_valid & i_ev_ready. Push and pop in the same cycle are allowed when not full; count unchanged. When full, push is blocked that cycle even if a pop occurs; the pending bit is retained, not lost. Pointers wrap modulo FIFO_DEPTH.
- o_overflow: set only by the cancellation rule above; i_clr_ovf clears it; set wins over clear in the same cycle.
- o_ev_ch, o_ev_press are don't-care when o_ev_valid = 0 but must not be X after reset.

Test Plan:
- STABLE_CYCLES=4, ACTIVE_LOW=1: drive i_raw[3] 1->0 and hold -> o_state[3] rises and o_press[3] pulses exactly 6 cycles after the edge; one event {ch=3, press=1} appears with o_ev_count=1.
- i_raw[5] low for 3 cycles then high -> no o_state change, no strobe, FIFO stays empty.
- Channels 7, 2 and 20 pressed in the same cycle, i_ev_ready=0 -> FIFO holds ch 2, 7, 20 in order; o_ev_count=3; each pops in successive cycles when i_ev_ready=1.
- FIFO_DEPTH=8, i_ev_ready=0, 10 distinct channel presses -> count saturates at 8; 2 events stay pending; after 2 pops they enter; no overflow.
- Hold ready low, full FIFO, press then release ch 9 (each stable) before it drains -> no event for ch 9, o_overflow=1; i_clr_ovf pulse -> 0.
- Assert i_rst_n low mid-count and with FIFO non-empty -> all outputs 0 immediately; after release with idle inputs no events emitted.
